// File: rtl/stream_demux2.sv
// Registered 1-to-2 stream router: steers each input beat into one of two
// single-entry output slots (A when in_sel=0, B when in_sel=1) with delivered-beat counters.
module stream_demux2 #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [WIDTH-1:0] b_data,
  output logic [CNT_W-1:0] a_count,
  output logic [CNT_W-1:0] b_count
);

  typedef enum logic {StEmpty, StFull} slot_e;

  slot_e            a_state_q, a_state_d;
  slot_e            b_state_q, b_state_d;
  logic [WIDTH-1:0] a_data_q, a_data_d;
  logic [WIDTH-1:0] b_data_q, b_data_d;
  logic [CNT_W-1:0] a_count_q, a_count_d;
  logic [CNT_W-1:0] b_count_q, b_count_d;

  logic a_hs, b_hs;
  logic accept, acc_a, acc_b;

  assign a_valid = (a_state_q == StFull);
  assign b_valid = (b_state_q == StFull);
  assign a_data  = a_data_q;
  assign b_data  = b_data_q;
  assign a_count = a_count_q;
  assign b_count = b_count_q;

  // Only the selected branch gates the input; a draining slot can take a new beat.
  assign in_ready = !rst && !flush &&
                    (in_sel ? (!b_valid || b_ready) : (!a_valid || a_ready));

  assign accept = in_valid && in_ready;
  assign acc_a  = accept && !in_sel;
  assign acc_b  = accept && in_sel;
  assign a_hs   = a_valid && a_ready;
  assign b_hs   = b_valid && b_ready;

  always_comb begin
    a_state_d = a_state_q;
    a_data_d  = a_data_q;
    unique case (a_state_q)
      StEmpty: if (acc_a) a_state_d = StFull;
      StFull:  if (a_hs && !acc_a) a_state_d = StEmpty;
      default: a_state_d = StEmpty;
    endcase
    if (acc_a) a_data_d = in_data;
    if (flush) a_state_d = StEmpty;
  end

  always_comb begin
    b_state_d = b_state_q;
    b_data_d  = b_data_q;
    unique case (b_state_q)
      StEmpty: if (acc_b) b_state_d = StFull;
      StFull:  if (b_hs && !acc_b) b_state_d = StEmpty;
      default: b_state_d = StEmpty;
    endcase
    if (acc_b) b_data_d = in_data;
    if (flush) b_state_d = StEmpty;
  end

  // Saturating counters; a handshake during a flush cycle still counts.
  always_comb begin
    a_count_d = a_count_q;
    b_count_d = b_count_q;
    if (a_hs && (a_count_q != {CNT_W{1'b1}})) a_count_d = a_count_q + CNT_W'(1);
    if (b_hs && (b_count_q != {CNT_W{1'b1}})) b_count_d = b_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_state_q <= StEmpty;
      b_state_q <= StEmpty;
      a_data_q  <= '0;
      b_data_q  <= '0;
      a_count_q <= '0;
      b_count_q <= '0;
    end else begin
      a_state_q <= a_state_d;
      b_state_q <= b_state_d;
      a_data_q  <= a_data_d;
      b_data_q  <= b_data_d;
      a_count_q <= a_count_d;
      b_count_q <= b_count_d;
    end
  end

endmodule

// File: tb/tb_stream_demux2.sv
// Self-checking bench for stream_demux2: directed steps plus a random burst,
// with per-branch scoreboard queues of expected beats.
module tb_stream_demux2;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned CMAX  = 15;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, in_sel, a_ready, b_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_ready, a_valid, b_valid;
  logic [WIDTH-1:0] a_data, b_data;
  logic [CNT_W-1:0] a_count, b_count;

  stream_demux2 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sel   (in_sel),
    .in_data  (in_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_data   (b_data),
    .a_count  (a_count),
    .b_count  (b_count)
  );

  always #5 clk = ~clk;

  int unsigned      vectors = 0;
  int unsigned      miscompares = 0;
  logic [WIDTH-1:0] qa[$];
  logic [WIDTH-1:0] qb[$];
  int unsigned      m_ac = 0;
  int unsigned      m_bc = 0;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle with the inputs already driven: check at negedge, update model at the edge.
  task automatic cycle();
    logic m_av, m_bv, exp_rdy;
    @(negedge clk);
    m_av    = (qa.size() != 0);
    m_bv    = (qb.size() != 0);
    exp_rdy = !rst && !flush && (in_sel ? (!m_bv || b_ready) : (!m_av || a_ready));
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    chk("a_valid", {31'd0, a_valid}, {31'd0, m_av});
    chk("b_valid", {31'd0, b_valid}, {31'd0, m_bv});
    chk("a_count", {28'd0, a_count}, m_ac);
    chk("b_count", {28'd0, b_count}, m_bc);
    if (m_av) chk("a_data", a_data, qa[0]);
    if (m_bv) chk("b_data", b_data, qb[0]);
    if (rst) begin
      qa.delete();
      qb.delete();
      m_ac = 0;
      m_bc = 0;
    end else begin
      if (m_av && a_ready) begin
        void'(qa.pop_front());
        if (m_ac < CMAX) m_ac++;
      end
      if (m_bv && b_ready) begin
        void'(qb.pop_front());
        if (m_bc < CMAX) m_bc++;
      end
      if (flush) begin
        qa.delete();
        qb.delete();
      end
      if (in_valid && exp_rdy) begin
        if (in_sel) qb.push_back(in_data);
        else qa.push_back(in_data);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic sel, input logic [WIDTH-1:0] d,
                       input logic ar, input logic br, input logic fl);
    in_valid = iv;
    in_sel   = sel;
    in_data  = d;
    a_ready  = ar;
    b_ready  = br;
    flush    = fl;
    cycle();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h99;
    a_ready = 1'b1; b_ready = 1'b1;
    @(posedge clk);
    #1;
    // Reset held two cycles with in_valid=1
    drive(1, 0, 32'h99, 1, 1, 0);
    drive(1, 1, 32'h98, 1, 1, 0);
    rst = 1'b0;
    drive(0, 0, 32'h0, 1, 1, 0);
    drive(0, 1, 32'h0, 1, 1, 0);

    // Steering
    drive(1, 0, 32'h11, 1, 1, 0);
    drive(1, 1, 32'h22, 1, 1, 0);
    drive(1, 0, 32'h33, 1, 1, 0);
    drive(0, 0, 32'h0, 1, 1, 0);
    drive(0, 0, 32'h0, 1, 1, 0);
    chk("steer_a_count", {28'd0, a_count}, 32'd2);
    chk("steer_b_count", {28'd0, b_count}, 32'd1);

    // Backpressure, then simultaneous drain + accept
    drive(1, 0, 32'hAA, 0, 1, 0);
    drive(1, 0, 32'hBB, 0, 1, 0);
    drive(1, 0, 32'hBB, 0, 1, 0);
    drive(1, 0, 32'hBB, 1, 1, 0);
    drive(0, 0, 32'h0, 0, 1, 0);
    chk("bp_a_data", a_data, 32'hBB);

    // Independence: A stalled and full, B still accepts
    drive(1, 1, 32'h5, 0, 0, 0);
    drive(0, 0, 32'h0, 0, 0, 0);
    chk("ind_b_data", b_data, 32'h5);

    // Flush with both full; A handshake in the flush cycle counts
    drive(1, 0, 32'h77, 1, 0, 1);
    drive(0, 0, 32'h0, 1, 1, 0);
    drive(0, 0, 32'h0, 1, 1, 0);

    // Random burst
    for (int i = 0; i < 300; i++) begin
      drive(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)), $urandom,
            logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
            ($urandom_range(0, 15) == 0));
    end

    // Saturation on B
    rst = 1'b1;
    drive(0, 0, 32'h0, 1, 1, 0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) drive(1, 1, 32'h100 + i, 0, 1, 0);
    drive(0, 1, 32'h0, 0, 1, 0);
    drive(0, 1, 32'h0, 0, 1, 0);
    chk("sat_b_count", {28'd0, b_count}, 32'd15);
    chk("sat_a_count", {28'd0, a_count}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
